// File: rtl/word2ascii_tx_pkg.sv
// Shared constants and state encoding for the hex-word-to-ASCII UART front end.
// The character-count helper keeps the counter sizing identical in all users.
package word2ascii_tx_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4
    } state_e;

    // Characters per word: one per hex digit plus the optional CR/LF pair.
    function automatic int char_total(input int num_digits, input int append_crlf);
        return num_digits + ((append_crlf != 0) ? 2 : 0);
    endfunction

endpackage

// File: rtl/word2ascii_tx_nib2ascii.sv
// Combinational nibble to uppercase hex ASCII encoder, zero-extended to the UART width.
// Mirror image of the receive-side ASCII-to-nibble decoder.
module nib2ascii
    import word2ascii_tx_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8
) (
    input  logic [3:0]              nib_in,
    output logic [PAYLOAD_BITS-1:0] ascii_out
);

    logic [7:0] code;

    always_comb begin
        code = ASCII_0 + {4'd0, nib_in};
        if (nib_in > 4'd9) begin
            code = ASCII_A + {4'd0, nib_in} - 8'd10;
        end
    end

    // Bits above the 8-bit code are tied low for wide UART characters.
    for (genvar gi = 0; gi < PAYLOAD_BITS; gi++) begin : g_bit
        if (gi < 8) begin : g_code
            assign ascii_out[gi] = code[gi];
        end else begin : g_zero
            assign ascii_out[gi] = 1'b0;
        end
    end

endmodule

// File: rtl/word2ascii_tx.sv
// Prints a captured word as uppercase hex (MSB digit first, optional CR/LF) through a
// byte-wide UART transmitter using a send / ack / done handshake per character.
module word2ascii_tx
    import word2ascii_tx_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int NUM_DIGITS   = 8,
    parameter int APPEND_CRLF  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_en,
    input  logic                    uart_tx_busy,
    output logic                    busy
);

    localparam int WORD_BITS = 4 * NUM_DIGITS;
    localparam int TOTAL     = char_total(NUM_DIGITS, APPEND_CRLF);
    localparam int CNT_BITS  = $clog2(TOTAL + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST   = CNT_BITS'(TOTAL);
    localparam logic [CNT_BITS-1:0] CNT_DIGITS = CNT_BITS'(NUM_DIGITS);

    state_e                  state_q, state_d;
    logic [WORD_BITS-1:0]    shift_q, shift_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    en_q, en_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic [WORD_BITS-1:0]    src_word;
    logic [CNT_BITS-1:0]     src_cnt;
    logic [PAYLOAD_BITS-1:0] digit_char;
    logic [PAYLOAD_BITS-1:0] char_next;
    logic                    accept;
    logic                    more_chars;

    // In IDLE the first character comes straight from word_in so it is ready with the first strobe.
    assign src_word   = (state_q == ST_IDLE) ? word_in : shift_q;
    assign src_cnt    = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign accept     = word_valid & ready_q;
    assign more_chars = (cnt_q != CNT_LAST);

    nib2ascii #(
        .PAYLOAD_BITS (PAYLOAD_BITS)
    ) u_nib2ascii (
        .nib_in    (src_word[WORD_BITS-1 -: 4]),
        .ascii_out (digit_char)
    );

    always_comb begin
        char_next = digit_char;
        if (src_cnt == CNT_DIGITS) begin
            char_next = PAYLOAD_BITS'(ASCII_CR);
        end else if (src_cnt > CNT_DIGITS) begin
            char_next = PAYLOAD_BITS'(ASCII_LF);
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = word_in;
                    cnt_d   = '0;
                    data_d  = char_next;
                    en_d    = ~uart_tx_busy;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Stay here with the strobe low until the transmitter is free.
                if (en_q) begin
                    state_d = ST_WAIT_ACK;
                end else begin
                    en_d = ~uart_tx_busy;
                end
            end
            ST_WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    shift_d = shift_q << 4;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (more_chars) begin
                    data_d  = char_next;
                    en_d    = ~uart_tx_busy;
                    state_d = ST_SEND;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign word_ready   = ready_q;
    assign uart_tx_data = data_q;
    assign uart_tx_en   = en_q;
    assign busy         = busy_q;

endmodule

// File: doc/word2ascii_tx.md
WORD2ASCII_TX -- requirements
Module: word2ascii_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8: UART character width.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: hex digits per word; word width = 4*NUM_DIGITS.
REQ-003 SHALL have parameter APPEND_CRLF, default 1: when 1, 0x0D then 0x0A follow the last digit.
REQ-004 SHALL have port clk  input  1  system clock; sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port word_in  input  4*NUM_DIGITS  value to print, MSB digit first.
REQ-007 SHALL have port word_valid  input  1  word_in is valid.
REQ-008 SHALL have port word_ready  output  1  block can accept a word.
REQ-009 SHALL have port uart_tx_data  output  PAYLOAD_BITS  ASCII character to the UART transmitter.
REQ-010 SHALL have port uart_tx_en  output  1  single-cycle send strobe to the UART transmitter.
REQ-011 SHALL have port uart_tx_busy  input  1  UART transmitter is shifting a character.
REQ-012 SHALL have port busy  output  1  a word is being emitted.

Function
REQ-013 SHALL accept a word on any cycle where word_valid and word_ready are both 1, capturing word_in into an internal shift register.
REQ-014 SHALL drive word_ready = 1 only in IDLE, registered, and 0 from the cycle after acceptance until the return to IDLE.
REQ-015 SHALL implement states IDLE, SEND, WAIT_ACK, WAIT_DONE, NEXT.
REQ-016 IDLE -> SEND on acceptance. SEND -> WAIT_ACK on the cycle uart_tx_en is asserted. WAIT_ACK -> WAIT_DONE when uart_tx_busy = 1. WAIT_DONE -> NEXT when uart_tx_busy = 0. NEXT -> SEND if characters remain, else -> IDLE.
REQ-017 In SEND, SHALL assert uart_tx_en for exactly one cycle, and only when uart_tx_busy = 0; while busy = 1, SHALL hold in SEND with en = 0.
REQ-018 SHALL hold uart_tx_data stable from the cycle en is asserted until the state leaves WAIT_DONE.
REQ-019 SHALL encode nibble 0-9 as 0x30-0x39 and nibble 10-15 as 0x41-0x46 (uppercase), zero-extended to PAYLOAD_BITS.
REQ-020 SHALL emit the most significant nibble first, shifting the word left by 4 per character; leading zeros are printed.
REQ-021 SHALL emit exactly NUM_DIGITS + 2*APPEND_CRLF characters per word, tracked by a character counter that never wraps past that count.
REQ-022 First uart_tx_en SHALL occur no earlier than 1 cycle after acceptance, and exactly 1 cycle after when uart_tx_busy = 0.
REQ-023 SHALL drive busy = 1 in every state except IDLE.
REQ-024 SHALL ignore word_valid and word_in while busy; the captured word is unaffected by later changes to word_in.
REQ-025 When the last character's WAIT_DONE exits, SHALL return to IDLE and may accept a new word on the next cycle (back-to-back words allowed).

Reset
REQ-026 When rst = 1 at a clock edge, SHALL enter IDLE with word_ready = 1, busy = 0, uart_tx_en = 0, uart_tx_data = 0, counter = 0, shift register = 0.
REQ-027 Reset mid-word SHALL abort the transfer with no further uart_tx_en; a character already strobed completes in the UART transmitter and is not retracted.
REQ-028 rst SHALL take priority over every simultaneous event, including acceptance.

Structure
REQ-029 A shared package SHALL hold the ASCII constants (ASCII_0 = 0x30, ASCII_A = 0x41, ASCII_CR = 0x0D, ASCII_LF = 0x0A) and the state encoding.
REQ-030 Nibble-to-ASCII conversion SHALL be a combinational sub-module nib2ascii (4-bit in, PAYLOAD_BITS out), the inverse of the receive-side ASCII decoder.

Verification
REQ-031 Accept 0x1234ABCD with the busy model at 3 cycles/char -> bytes 31 32 33 34 41 42 43 44 0D 0A in order, one en pulse each, then word_ready = 1.
REQ-032 Accept 0x00000000 with APPEND_CRLF = 0 -> eight 0x30 bytes, then IDLE.
REQ-033 uart_tx_busy held 1 for 50 cycles during SEND -> no en pulse; en fires 1 cycle after busy drops.
REQ-034 word_valid held 1 with changing word_in during transfer -> only the first word is printed; the second word is accepted only after the final LF.
REQ-035 rst asserted after the 3rd en pulse -> no further en; word_ready = 1 and busy = 0 on the cycle after rst.
REQ-036 Word 0xFFFFFFFF accepted on the same edge rst = 1 -> not accepted; no en pulse follows.
